qdec_step_gen: RTL and testbench

Quadrature step generator feeding the up/down counter stage. Takes two asynchronous quadrature lines (A/B) from an encoder or test fixture, synchronises and glitch-filters them, and decodes valid Gray-code transitions into a single-cycle count-enable pulse plus a direction level. The outputs connect directly to the counter's `ce_i`/`up_i` inputs. Illegal double-bit transitions are flagged on a sticky error output.

---
 rtl/qdec_step_gen.sv | 170 +++++++++++++++++
 tb/tb_qdec_step_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_step_gen.sv
// Quadrature step generator: synchronises and filters A/B, decodes Gray-code steps into ce/up pulses.
// Define QDEC_X4_EN for x4 decoding (pulse on every valid edge); default build is x1 decoding.
module qdec_step_gen #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic en_i,
  input  logic clr_err_i,
  output logic ce_o,
  output logic up_o,
  output logic err_o
);

  localparam int unsigned CNT_W     = $clog2(FILT_LEN + 1);
  localparam int unsigned BLANK_LEN = FILT_LEN + 3;
  localparam int unsigned BLK_W     = $clog2(BLANK_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_LEN - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] filt;
  logic [1:0] prev_q;

  logic [1:0] diff_c;
  logic       single_c;
  logic       dbl_c;
  logic       dir_up_c;
  logic       pulse_c;

  state_t           state_q;
  state_t           state_d;
  logic [BLK_W-1:0] blank_cnt_q;
  logic [BLK_W-1:0] blank_cnt_d;
  logic             run_c;

  // Two-flop synchroniser, bit 1 = A, bit 0 = B
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {a_i, b_i};
      sync2_q <= sync1_q;
    end
  end

  // Per-line glitch filter: follow the synchronised line only after FILT_LEN cycles of disagreement
  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic [CNT_W-1:0] cnt_q;
    logic             f_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        f_q   <= 1'b0;
      end else if (sync2_q[i] == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        f_q   <= sync2_q[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign filt[i] = f_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 2'b00;
    end else begin
      prev_q <= filt;
    end
  end

  // Next {A,B} state when moving in the up direction: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] up_succ(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Transition classifier
  always_comb begin
    diff_c   = filt ^ prev_q;
    single_c = diff_c[1] ^ diff_c[0];
    dbl_c    = diff_c[1] & diff_c[0];
    dir_up_c = (filt == up_succ(prev_q));
    pulse_c  = 1'b0;
`ifdef QDEC_X4_EN
    pulse_c  = single_c;
`else
    // One pulse per cycle, anchored on the 01 <-> 00 edge so reversals cancel
    pulse_c  = single_c &&
               (((prev_q == 2'b01) && (filt == 2'b00)) ||
                ((prev_q == 2'b00) && (filt == 2'b01)));
`endif
  end

  // Start-up blanking state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      ST_BLANK: begin
        blank_cnt_d = blank_cnt_q + BLK_W'(1);
        if (blank_cnt_q == BLK_LAST) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    run_c = 1'b0;
    case (state_q)
      ST_RUN:  run_c = 1'b1;
      default: run_c = 1'b0;
    endcase
  end

  // Registered step/direction/error outputs; set of err_o takes priority over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_o  <= 1'b0;
      up_o  <= 1'b1;
      err_o <= 1'b0;
    end else begin
      ce_o <= run_c & pulse_c & en_i;
      if (run_c && single_c) begin
        up_o <= dir_up_c;
      end
      if (run_c && dbl_c) begin
        err_o <= 1'b1;
      end else if (clr_err_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qdec_step_gen.sv
// Scoreboard bench for qdec_step_gen: directed A/B sequences push expected events, a monitor checks them.
module tb_qdec_step_gen;

  localparam int unsigned FILT_LEN = 4;
  localparam int unsigned LAT      = FILT_LEN + 3;
  localparam int          K_NONE   = 0;
  localparam int          K_STEP   = 1;
  localparam int          K_ERR    = 2;
`ifdef QDEC_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  typedef struct packed {
    logic        is_err;
    logic        up;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst, a_i, b_i, en_i, clr_err_i;
  logic ce_o, up_o, err_o;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic blank_chk = 1'b1;
  logic lvl_req   = 1'b0;
  logic exp_up    = 1'b1;
  logic exp_err   = 1'b0;
  logic done_req  = 1'b0;
  logic err_q     = 1'b0;

  qdec_step_gen #(.FILT_LEN(FILT_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_i       (a_i),
    .b_i       (b_i),
    .en_i      (en_i),
    .clr_err_i (clr_err_i),
    .ce_o      (ce_o),
    .up_o      (up_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    ev_t ev;
    #1;
    if (blank_chk) begin
      checks++;
      if (ce_o !== 1'b0 || up_o !== 1'b1 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL blank cyc=%0d got ce=%b up=%b err=%b required ce=0 up=1 err=0",
                 cyc, ce_o, up_o, err_o);
      end
    end
    if (lvl_req) begin
      checks++;
      if (up_o !== exp_up || err_o !== exp_err) begin
        errors++;
        $display("FAIL level cyc=%0d got up=%b err=%b required up=%b err=%b",
                 cyc, up_o, err_o, exp_up, exp_err);
      end
    end
    if (ce_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ce_event cyc=%0d got unexpected ce pulse required none", cyc);
      end else begin
        ev = exp_q.pop_front();
        if (ev.is_err || ev.up !== up_o || ev.cyc != cyc) begin
          errors++;
          $display("FAIL ce_event got ce up=%b cyc=%0d required err_ev=%b up=%b cyc=%0d",
                   up_o, cyc, ev.is_err, ev.up, ev.cyc);
        end
      end
    end
    if (err_o === 1'b1 && err_q !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL err_event cyc=%0d got unexpected err rise required none", cyc);
      end else begin
        ev = exp_q.pop_front();
        if (!ev.is_err || ev.cyc != cyc) begin
          errors++;
          $display("FAIL err_event got err rise cyc=%0d required err_ev=%b cyc=%0d",
                   cyc, ev.is_err, ev.cyc);
        end
      end
    end
    err_q <= err_o;
    if (done_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending got %0d outstanding events required 0", exp_q.size());
      end
    end
  end

  task automatic drive(input logic [1:0] ab, input int hold, input int kind,
                       input logic up, input logic x1p);
    ev_t ev;
    @(negedge clk);
    a_i = ab[1];
    b_i = ab[0];
    if (kind == K_STEP && en_i && (X4 || x1p)) begin
      ev.is_err = 1'b0;
      ev.up     = up;
      ev.cyc    = cyc + LAT;
      exp_q.push_back(ev);
    end else if (kind == K_ERR) begin
      ev.is_err = 1'b1;
      ev.up     = 1'b0;
      ev.cyc    = cyc + LAT;
      exp_q.push_back(ev);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic check_lvl(input logic up, input logic err);
    @(negedge clk);
    exp_up  = up;
    exp_err = err;
    lvl_req = 1'b1;
    @(negedge clk);
    lvl_req = 1'b0;
  endtask

  task automatic clr_pulse(input logic up);
    @(negedge clk);
    clr_err_i = 1'b1;
    exp_up    = up;
    exp_err   = 1'b0;
    lvl_req   = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    lvl_req   = 1'b0;
  endtask

  initial begin
    ev_t ev;
    rst = 1'b1; a_i = 1'b1; b_i = 1'b1; en_i = 1'b1; clr_err_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Lines already at 11: the 00 -> 11 settle must stay hidden by blanking
    repeat (12) @(negedge clk);
    blank_chk = 1'b0;

    // Walk from 11 back to 00 going up
    drive(2'b01, 20, K_STEP, 1'b1, 1'b0);
    drive(2'b00, 20, K_STEP, 1'b1, 1'b1);
    // Full up cycle
    drive(2'b10, 20, K_STEP, 1'b1, 1'b0);
    drive(2'b11, 20, K_STEP, 1'b1, 1'b0);
    drive(2'b01, 20, K_STEP, 1'b1, 1'b0);
    drive(2'b00, 20, K_STEP, 1'b1, 1'b1);
    check_lvl(1'b1, 1'b0);
    // Full down cycle
    drive(2'b01, 20, K_STEP, 1'b0, 1'b1);
    drive(2'b11, 20, K_STEP, 1'b0, 1'b0);
    drive(2'b10, 20, K_STEP, 1'b0, 1'b0);
    drive(2'b00, 20, K_STEP, 1'b0, 1'b0);
    check_lvl(1'b0, 1'b0);

    // 3-cycle glitch on A is discarded
    drive(2'b10, 3, K_NONE, 1'b0, 1'b0);
    drive(2'b00, 20, K_NONE, 1'b0, 1'b0);
    check_lvl(1'b0, 1'b0);
    // 4-cycle pulse on A passes: up then down
    drive(2'b10, 4, K_STEP, 1'b1, 1'b0);
    drive(2'b00, 20, K_STEP, 1'b0, 1'b0);
    check_lvl(1'b0, 1'b0);

    // Double-bit jump flags an error, direction untouched
    drive(2'b11, 20, K_ERR, 1'b0, 1'b0);
    check_lvl(1'b0, 1'b1);
    clr_pulse(1'b0);
    repeat (3) @(negedge clk);
    // Second jump with clear asserted across the setting edge: set wins
    @(negedge clk);
    a_i = 1'b0;
    b_i = 1'b0;
    ev.is_err = 1'b1;
    ev.up     = 1'b0;
    ev.cyc    = cyc + LAT;
    exp_q.push_back(ev);
    repeat (5) @(negedge clk);
    clr_err_i = 1'b1;
    repeat (2) @(negedge clk);
    clr_err_i = 1'b0;
    exp_up    = 1'b0;
    exp_err   = 1'b1;
    lvl_req   = 1'b1;
    @(negedge clk);
    lvl_req = 1'b0;
    repeat (12) @(negedge clk);
    clr_pulse(1'b0);
    check_lvl(1'b0, 1'b0);

    // Disabled steps still update direction
    @(negedge clk);
    en_i = 1'b0;
    drive(2'b10, 20, K_STEP, 1'b1, 1'b0);
    drive(2'b11, 20, K_STEP, 1'b1, 1'b0);
    check_lvl(1'b1, 1'b0);
    @(negedge clk);
    en_i = 1'b1;
    repeat (20) @(negedge clk);
    drive(2'b01, 20, K_STEP, 1'b1, 1'b0);
    drive(2'b00, 20, K_STEP, 1'b1, 1'b1);
    check_lvl(1'b1, 1'b0);

    @(negedge clk);
    done_req = 1'b1;
    @(negedge clk);
    done_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
